// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves A/B operands through EX/WB forwarding, detects
// load-use hazards, and registers operands plus control into the ID/EX register.
module id_ex_operand_stage #(
   parameter int WIDTH    = 32,
   parameter int RADDR    = 5,
   parameter int FLAG_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RADDR-1:0] id_AA,
   input  logic [RADDR-1:0] id_BA,
   input  logic             id_useA,
   input  logic             id_useB,
   input  logic [RADDR-1:0] id_DA,
   input  logic             id_RW,
   input  logic             id_MD,
   input  logic             id_MW,
   input  logic [4:0]       id_FS,
   input  logic [WIDTH-1:0] id_imm,
   input  logic             id_MB,
   input  logic [WIDTH-1:0] A_data,
   input  logic [WIDTH-1:0] B_data,
   input  logic             ex_fwd_RW,
   input  logic             ex_fwd_MD,
   input  logic [RADDR-1:0] ex_fwd_DA,
   input  logic [4:0]       ex_fwd_FS,
   input  logic [WIDTH-1:0] ex_fwd_result,
   input  logic [3:0]       ex_fwd_flags,
   input  logic             wb_RW,
   input  logic [RADDR-1:0] wb_DA,
   input  logic [4:0]       wb_FS,
   input  logic [WIDTH-1:0] wb_data,
   input  logic [3:0]       wb_flags,
   input  logic             flush,
   input  logic             hold,
   output logic             stall,
   output logic             ex_valid,
   output logic             ex_RW,
   output logic             ex_MD,
   output logic             ex_MW,
   output logic [RADDR-1:0] ex_DA,
   output logic [4:0]       ex_FS,
   output logic [WIDTH-1:0] ex_A,
   output logic [WIDTH-1:0] ex_B,
   output logic [WIDTH-1:0] ex_Bst,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [RADDR-1:0] FLAG_ADDR = RADDR'(FLAG_REG);

   logic [1:0][RADDR-1:0] op_addr;
   logic [1:0][WIDTH-1:0] op_raw;
   logic [1:0][WIDTH-1:0] op_val;
   logic [WIDTH-1:0]      ex_flag_word;
   logic [WIDTH-1:0]      wb_flag_word;

   assign op_addr[0]   = id_AA;
   assign op_addr[1]   = id_BA;
   assign op_raw[0]    = A_data;
   assign op_raw[1]    = B_data;
   assign ex_flag_word = {{(WIDTH-4){1'b0}}, ex_fwd_flags};
   assign wb_flag_word = {{(WIDTH-4){1'b0}}, wb_flags};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         logic is_r0;
         logic is_flag;
         logic ex_rw_hit;
         logic wb_rw_hit;
         logic ex_flag_hit;
         logic wb_flag_hit;

         assign is_r0       = (op_addr[gi] == '0);
         assign is_flag     = (op_addr[gi] == FLAG_ADDR);
         assign ex_rw_hit   = ex_fwd_RW && (ex_fwd_DA == op_addr[gi]);
         assign wb_rw_hit   = wb_RW && (wb_DA == op_addr[gi]);
         // A register write to the flag register shadows a flag update from the same stage.
         assign ex_flag_hit = is_flag && (ex_fwd_FS != 5'd0) && !ex_rw_hit;
         assign wb_flag_hit = is_flag && (wb_FS != 5'd0) && !wb_rw_hit;

         assign op_val[gi] = is_r0                     ? op_raw[gi]    :
                             (ex_rw_hit && !ex_fwd_MD) ? ex_fwd_result :
                             ex_flag_hit               ? ex_flag_word  :
                             wb_rw_hit                 ? wb_data       :
                             wb_flag_hit               ? wb_flag_word  :
                                                         op_raw[gi];
      end
   endgenerate

   logic load_in_ex;
   logic hazard_a;
   logic hazard_b;

   assign load_in_ex = ex_fwd_MD && ex_fwd_RW && (ex_fwd_DA != '0);
   assign hazard_a   = id_useA && (id_AA == ex_fwd_DA);
   assign hazard_b   = id_useB && (id_BA == ex_fwd_DA);
   assign stall      = id_valid && load_in_ex && (hazard_a || hazard_b) && !flush;

   logic             ex_valid_reg;
   logic             ex_RW_reg;
   logic             ex_MD_reg;
   logic             ex_MW_reg;
   logic [RADDR-1:0] ex_DA_reg;
   logic [4:0]       ex_FS_reg;
   logic [WIDTH-1:0] ex_A_reg;
   logic [WIDTH-1:0] ex_B_reg;
   logic [WIDTH-1:0] ex_Bst_reg;
   logic [CNT_W-1:0] stall_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_reg    <= 1'b0;
         ex_RW_reg       <= 1'b0;
         ex_MD_reg       <= 1'b0;
         ex_MW_reg       <= 1'b0;
         ex_DA_reg       <= '0;
         ex_FS_reg       <= '0;
         ex_A_reg        <= '0;
         ex_B_reg        <= '0;
         ex_Bst_reg      <= '0;
         stall_count_reg <= '0;
      end else if (!hold) begin
         if (flush || stall || !id_valid) begin
            ex_valid_reg <= 1'b0;
            ex_RW_reg    <= 1'b0;
            ex_MD_reg    <= 1'b0;
            ex_MW_reg    <= 1'b0;
            ex_DA_reg    <= '0;
            ex_FS_reg    <= '0;
            ex_A_reg     <= '0;
            ex_B_reg     <= '0;
            ex_Bst_reg   <= '0;
         end else begin
            ex_valid_reg <= 1'b1;
            ex_RW_reg    <= id_RW;
            ex_MD_reg    <= id_MD;
            ex_MW_reg    <= id_MW;
            ex_DA_reg    <= id_DA;
            ex_FS_reg    <= id_FS;
            ex_A_reg     <= op_val[0];
            ex_B_reg     <= id_MB ? id_imm : op_val[1];
            ex_Bst_reg   <= op_val[1];
         end
         if (stall && (stall_count_reg != '1))
            stall_count_reg <= stall_count_reg + 1'b1;
      end
   end

   assign ex_valid    = ex_valid_reg;
   assign ex_RW       = ex_RW_reg;
   assign ex_MD       = ex_MD_reg;
   assign ex_MW       = ex_MW_reg;
   assign ex_DA       = ex_DA_reg;
   assign ex_FS       = ex_FS_reg;
   assign ex_A        = ex_A_reg;
   assign ex_B        = ex_B_reg;
   assign ex_Bst      = ex_Bst_reg;
   assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Testbench for id_ex_operand_stage: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_id_ex_operand_stage;

   localparam int WIDTH = 32;
   localparam int RADDR = 5;
   localparam int CNT_W = 4;   // narrow counter so saturation is reachable quickly

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid, id_useA, id_useB, id_RW, id_MD, id_MW, id_MB;
   logic [RADDR-1:0] id_AA, id_BA, id_DA;
   logic [4:0]       id_FS;
   logic [WIDTH-1:0] id_imm, A_data, B_data;
   logic             ex_fwd_RW, ex_fwd_MD;
   logic [RADDR-1:0] ex_fwd_DA;
   logic [4:0]       ex_fwd_FS;
   logic [WIDTH-1:0] ex_fwd_result;
   logic [3:0]       ex_fwd_flags;
   logic             wb_RW;
   logic [RADDR-1:0] wb_DA;
   logic [4:0]       wb_FS;
   logic [WIDTH-1:0] wb_data;
   logic [3:0]       wb_flags;
   logic             flush, hold;
   logic             stall;
   logic             ex_valid, ex_RW, ex_MD, ex_MW;
   logic [RADDR-1:0] ex_DA;
   logic [4:0]       ex_FS;
   logic [WIDTH-1:0] ex_A, ex_B, ex_Bst;
   logic [CNT_W-1:0] stall_count;

   int total = 0;
   int bad   = 0;

   id_ex_operand_stage #(.WIDTH(WIDTH), .RADDR(RADDR), .FLAG_REG(31), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_AA(id_AA), .id_BA(id_BA),
      .id_useA(id_useA), .id_useB(id_useB), .id_DA(id_DA), .id_RW(id_RW), .id_MD(id_MD),
      .id_MW(id_MW), .id_FS(id_FS), .id_imm(id_imm), .id_MB(id_MB),
      .A_data(A_data), .B_data(B_data),
      .ex_fwd_RW(ex_fwd_RW), .ex_fwd_MD(ex_fwd_MD), .ex_fwd_DA(ex_fwd_DA), .ex_fwd_FS(ex_fwd_FS),
      .ex_fwd_result(ex_fwd_result), .ex_fwd_flags(ex_fwd_flags),
      .wb_RW(wb_RW), .wb_DA(wb_DA), .wb_FS(wb_FS), .wb_data(wb_data), .wb_flags(wb_flags),
      .flush(flush), .hold(hold), .stall(stall),
      .ex_valid(ex_valid), .ex_RW(ex_RW), .ex_MD(ex_MD), .ex_MW(ex_MW), .ex_DA(ex_DA),
      .ex_FS(ex_FS), .ex_A(ex_A), .ex_B(ex_B), .ex_Bst(ex_Bst), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Reference model state: what the ID/EX register should hold.
   typedef struct packed {
      logic             valid, rw, md, mw;
      logic [RADDR-1:0] da;
      logic [4:0]       fs;
      logic [WIDTH-1:0] a, b, bst;
      logic [CNT_W-1:0] cnt;
   } ex_state_t;

   ex_state_t model;

   function automatic logic [WIDTH-1:0] ref_operand(input logic [RADDR-1:0] addr,
                                                    input logic [WIDTH-1:0] raw);
      logic ex_writes, wb_writes;
      ex_writes = ex_fwd_RW && ex_fwd_DA == addr;
      wb_writes = wb_RW && wb_DA == addr;
      if (addr == 0)                                 return raw;
      if (ex_writes && !ex_fwd_MD)                   return ex_fwd_result;
      if (addr == 31 && ex_fwd_FS != 0 && !ex_writes) return WIDTH'(ex_fwd_flags);
      if (wb_writes)                                 return wb_data;
      if (addr == 31 && wb_FS != 0 && !wb_writes)    return WIDTH'(wb_flags);
      return raw;
   endfunction

   function automatic logic ref_stall();
      logic uses_load;
      uses_load = (id_useA && id_AA == ex_fwd_DA) || (id_useB && id_BA == ex_fwd_DA);
      return id_valid && ex_fwd_MD && ex_fwd_RW && ex_fwd_DA != 0 && uses_load && !flush;
   endfunction

   function automatic ex_state_t dut_state();
      return {ex_valid, ex_RW, ex_MD, ex_MW, ex_DA, ex_FS, ex_A, ex_B, ex_Bst, stall_count};
   endfunction

   // Advance the model by one edge using the present inputs, then clock the DUT.
   task automatic cycle();
      ex_state_t nxt;
      logic      stl;
      nxt = model;
      stl = ref_stall();
      if (rst) begin
         nxt = '0;
      end else if (!hold) begin
         if (flush || stl || !id_valid) begin
            nxt.valid = 0; nxt.rw = 0; nxt.md = 0; nxt.mw = 0;
            nxt.da = 0; nxt.fs = 0; nxt.a = 0; nxt.b = 0; nxt.bst = 0;
         end else begin
            nxt.valid = 1; nxt.rw = id_RW; nxt.md = id_MD; nxt.mw = id_MW;
            nxt.da = id_DA; nxt.fs = id_FS;
            nxt.a   = ref_operand(id_AA, A_data);
            nxt.bst = ref_operand(id_BA, B_data);
            nxt.b   = id_MB ? id_imm : nxt.bst;
         end
         if (stl && model.cnt != {CNT_W{1'b1}}) nxt.cnt = model.cnt + 1;
      end
      @(posedge clk);
      #1;
      model = nxt;
   endtask

   task automatic quiet_inputs();
      rst = 0; flush = 0; hold = 0;
      id_valid = 1; id_AA = 1; id_BA = 2; id_useA = 1; id_useB = 1; id_DA = 4;
      id_RW = 1; id_MD = 0; id_MW = 0; id_FS = 5'd2; id_imm = 32'h0000_0F0F; id_MB = 0;
      A_data = 32'h1111_0001; B_data = 32'h2222_0002;
      ex_fwd_RW = 0; ex_fwd_MD = 0; ex_fwd_DA = 0; ex_fwd_FS = 0;
      ex_fwd_result = 32'hDEAD_0000; ex_fwd_flags = 0;
      wb_RW = 0; wb_DA = 0; wb_FS = 0; wb_data = 32'hBEEF_0000; wb_flags = 0;
   endtask

   task automatic test_reset();
      quiet_inputs();
      rst = 1; flush = 1;
      cycle();
      cycle();
      total++;
      if (dut_state() !== ex_state_t'('0)) begin
         bad++; $display("FAIL reset_state got=%h exp=0", dut_state());
      end
      total++;
      if (stall_count !== 0) begin
         bad++; $display("FAIL reset_count got=%0d exp=0", stall_count);
      end
      rst = 0; flush = 0;
      cycle();
      total++;
      if (ex_valid !== 1'b1 || ex_A !== 32'h1111_0001) begin
         bad++; $display("FAIL reset_release valid=%b A=%h exp valid=1 A=11110001", ex_valid, ex_A);
      end
      $display("test_reset: state after release=%h", dut_state());
   endtask

   task automatic test_ex_forward();
      quiet_inputs();
      id_AA = 5; A_data = 0; ex_fwd_RW = 1; ex_fwd_DA = 5; ex_fwd_result = 32'h1234;
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL ex_fwd_stall got=%b exp=0", stall);
      end
      cycle();
      total++;
      if (ex_A !== 32'h1234) begin
         bad++; $display("FAIL ex_fwd_A got=%h exp=00001234", ex_A);
      end
      $display("test_ex_forward: ex_A=%h", ex_A);
   endtask

   task automatic test_both_match();
      quiet_inputs();
      id_BA = 7; ex_fwd_RW = 1; ex_fwd_DA = 7; ex_fwd_result = 32'hAA;
      wb_RW = 1; wb_DA = 7; wb_data = 32'hBB;
      cycle();
      total++;
      if (ex_B !== 32'hAA || ex_Bst !== 32'hAA) begin
         bad++; $display("FAIL both_match B=%h Bst=%h exp=000000aa", ex_B, ex_Bst);
      end
      id_MB = 1;
      cycle();
      total++;
      if (ex_B !== 32'h0F0F || ex_Bst !== 32'hAA) begin
         bad++; $display("FAIL imm_select B=%h Bst=%h exp B=00000f0f Bst=000000aa", ex_B, ex_Bst);
      end
      ex_fwd_RW = 0; id_MB = 0;
      cycle();
      total++;
      if (ex_B !== 32'hBB) begin
         bad++; $display("FAIL wb_forward B=%h exp=000000bb", ex_B);
      end
      $display("test_both_match: ex_B=%h ex_Bst=%h", ex_B, ex_Bst);
   endtask

   task automatic test_load_use();
      quiet_inputs();
      id_AA = 3; ex_fwd_RW = 1; ex_fwd_MD = 1; ex_fwd_DA = 3;
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL load_use_stall got=%b exp=1", stall);
      end
      cycle();
      total++;
      if (ex_valid !== 1'b0 || ex_RW !== 1'b0 || ex_A !== 0) begin
         bad++; $display("FAIL load_use_bubble valid=%b RW=%b A=%h exp 0 0 0", ex_valid, ex_RW, ex_A);
      end
      ex_fwd_RW = 0; ex_fwd_MD = 0; ex_fwd_DA = 0;
      wb_RW = 1; wb_DA = 3; wb_data = 32'hCAFE_F00D;
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL load_use_release got=%b exp=0", stall);
      end
      cycle();
      total++;
      if (ex_A !== 32'hCAFE_F00D || stall_count !== 1) begin
         bad++; $display("FAIL load_use_wb A=%h cnt=%0d exp A=cafef00d cnt=1", ex_A, stall_count);
      end
      $display("test_load_use: ex_A=%h stall_count=%0d", ex_A, stall_count);
   endtask

   task automatic test_flag_forward();
      quiet_inputs();
      id_AA = 31; ex_fwd_FS = 3; ex_fwd_flags = 4'b1001;
      cycle();
      total++;
      if (ex_A !== 32'h9) begin
         bad++; $display("FAIL ex_flag A=%h exp=00000009", ex_A);
      end
      ex_fwd_RW = 1; ex_fwd_DA = 31; ex_fwd_result = 32'h55;
      cycle();
      total++;
      if (ex_A !== 32'h55) begin
         bad++; $display("FAIL ex_rw_beats_flag A=%h exp=00000055", ex_A);
      end
      ex_fwd_RW = 0; ex_fwd_FS = 0; wb_FS = 1; wb_flags = 4'b0110;
      cycle();
      total++;
      if (ex_A !== 32'h6) begin
         bad++; $display("FAIL wb_flag A=%h exp=00000006", ex_A);
      end
      $display("test_flag_forward: ex_A=%h", ex_A);
   endtask

   task automatic test_flush_hold();
      quiet_inputs();
      id_AA = 3; ex_fwd_RW = 1; ex_fwd_MD = 1; ex_fwd_DA = 3; flush = 1;
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL flush_stall got=%b exp=0", stall);
      end
      cycle();
      total++;
      if (ex_valid !== 1'b0) begin
         bad++; $display("FAIL flush_bubble valid=%b exp=0", ex_valid);
      end
      quiet_inputs();
      cycle();
      hold = 1; id_AA = 3; ex_fwd_RW = 1; ex_fwd_MD = 1; ex_fwd_DA = 3;
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if (dut_state() !== model || ex_A !== 32'h1111_0001 || ex_valid !== 1'b1) begin
            bad++; $display("FAIL hold_freeze cyc=%0d got=%h exp=%h", i, dut_state(), model);
         end
      end
      quiet_inputs();
      id_AA = 0; A_data = 32'h77; ex_fwd_RW = 1; ex_fwd_DA = 0; ex_fwd_result = 32'h99;
      wb_RW = 1; wb_DA = 0; wb_data = 32'h88;
      cycle();
      total++;
      if (ex_A !== 32'h77) begin
         bad++; $display("FAIL r0_raw A=%h exp=00000077", ex_A);
      end
      $display("test_flush_hold: ex_A=%h stall_count=%0d", ex_A, stall_count);
   endtask

   task automatic test_saturation();
      quiet_inputs();
      id_BA = 9; ex_fwd_RW = 1; ex_fwd_MD = 1; ex_fwd_DA = 9;
      for (int i = 0; i < 20; i++) cycle();
      total++;
      if (stall_count !== {CNT_W{1'b1}}) begin
         bad++; $display("FAIL saturate cnt=%0d exp=%0d", stall_count, {CNT_W{1'b1}});
      end
      $display("test_saturation: stall_count=%0d", stall_count);
   endtask

   function automatic logic [RADDR-1:0] rnd_addr();
      logic [RADDR-1:0] pick;
      pick = RADDR'($urandom_range(0, 8));
      return (pick == 8) ? RADDR'(31) : pick;
   endfunction

   task automatic test_random();
      quiet_inputs();
      rst = 1;
      cycle();
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 99) < 2);
         hold     = ($urandom_range(0, 99) < 10);
         flush    = ($urandom_range(0, 99) < 10);
         id_valid = ($urandom_range(0, 99) < 85);
         id_AA = rnd_addr(); id_BA = rnd_addr(); id_DA = rnd_addr();
         id_useA = 1'($urandom); id_useB = 1'($urandom);
         id_RW = 1'($urandom); id_MD = 1'($urandom); id_MW = 1'($urandom);
         id_FS = 5'($urandom); id_imm = $urandom; id_MB = 1'($urandom);
         A_data = $urandom; B_data = $urandom;
         ex_fwd_RW = 1'($urandom); ex_fwd_MD = ($urandom_range(0, 3) == 0);
         ex_fwd_DA = rnd_addr(); ex_fwd_FS = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
         ex_fwd_result = $urandom; ex_fwd_flags = 4'($urandom);
         wb_RW = 1'($urandom); wb_DA = rnd_addr();
         wb_FS = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
         wb_data = $urandom; wb_flags = 4'($urandom);
         #1;
         total++;
         if (stall !== ref_stall()) begin
            bad++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, ref_stall());
         end
         cycle();
         total++;
         if (dut_state() !== model) begin
            bad++; $display("FAIL rand_state n=%0d got=%h exp=%h", n, dut_state(), model);
         end
      end
      $display("test_random: 400 cycles, final stall_count=%0d", stall_count);
   endtask

   initial begin
      model = '0;
      quiet_inputs();
      test_reset();
      test_ex_forward();
      test_both_match();
      test_load_use();
      test_flag_forward();
      test_flush_hold();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file read ports.
- Takes the decoded instruction fields and the raw A/B read data, and resolves data hazards by forwarding from the EX and WB stages.
- Detects load-use hazards and stalls the front end while inserting a bubble.
- Registers the resolved operands and control into the ID/EX pipeline register consumed by the ALU stage.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register address width.
- FLAG_REG, 31, index of the flag register, which is written as {28'b0,Z,V,N,C} whenever FS!=0.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_AA  in  RADDR  source A address, also driven to the register file.
- id_BA  in  RADDR  source B address.
- id_useA  in  1  instruction reads A.
- id_useB  in  1  instruction reads B.
- id_DA  in  RADDR  destination register.
- id_RW  in  1  register write enable.
- id_MD  in  1  result comes from memory (load).
- id_MW  in  1  memory write.
- id_FS  in  5  ALU function select.
- id_imm  in  WIDTH  extended immediate.
- id_MB  in  1  select immediate as B.
- A_data  in  WIDTH  register file port A read data.
- B_data  in  WIDTH  register file port B read data.
- ex_fwd_RW, ex_fwd_MD  in  1  write enable and load flag of the instruction currently in EX.
- ex_fwd_DA  in  RADDR  destination of the instruction in EX.
- ex_fwd_FS  in  5  function select of the instruction in EX.
- ex_fwd_result  in  WIDTH  ALU result of the instruction in EX.
- ex_fwd_flags  in  4  {Z,V,N,C} of the instruction in EX.
- wb_RW  in  1  WB write enable (same signal as the register file RW).
- wb_DA  in  RADDR  WB destination.
- wb_FS  in  5  WB function select.
- wb_data  in  WIDTH  WB write data.
- wb_flags  in  4  WB {Z,V,N,C}.
- flush  in  1  taken branch; kill the instruction in ID.
- hold  in  1  global freeze from memory.
- stall  out  1  combinational; freeze PC and IF/ID.
- ex_valid, ex_RW, ex_MD, ex_MW  out  1  registered control.
- ex_DA  out  RADDR  registered destination.
- ex_FS  out  5  registered function select.
- ex_A  out  WIDTH  registered forwarded operand A.
- ex_B  out  WIDTH  registered forwarded operand B, or id_imm when MB=1.
- ex_Bst  out  WIDTH  registered forwarded B value for stores.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: all ex_* outputs are 0 (bubble), and stall_count is 0. Reset overrides flush, hold and stall.
- Operand resolution (combinational, per operand X in {A,B}, addr = id_AA/id_BA), in priority order:
  1. addr==0: use the raw read data. R0 is never written and never forwarded.
  2. EX match (ex_fwd_RW && ex_fwd_DA==addr && !ex_fwd_MD): use ex_fwd_result.
  3. EX flag match (addr==FLAG_REG && ex_fwd_FS!=0 && no EX RW match on addr): use {28'b0,ex_fwd_flags}.
  4. WB match (wb_RW && wb_DA==addr): use wb_data. This is needed because the register file writes on the same edge on which this stage samples.
  5. WB flag match (addr==FLAG_REG && wb_FS!=0 && no WB RW match): use {28'b0,wb_flags}.
  6. Otherwise: use A_data/B_data.
- An RW write to FLAG_REG beats a flag write in the same stage; this matches the register file's write priority.
- Load-use stall: stall = id_valid && ex_fwd_MD && ex_fwd_RW && ex_fwd_DA!=0 && ((id_useA && id_AA==ex_fwd_DA) || (id_useB && id_BA==ex_fwd_DA)) && !flush.
- Next-state rules on each clk edge, in priority order:
  1. rst: reset as above.
  2. hold: all ex_* outputs and stall_count are unchanged.
  3. flush or stall or !id_valid: load a bubble (ex_valid, ex_RW, ex_MD, ex_MW = 0; ex_FS = 0; data = 0).
  4. Otherwise: load the resolved operands and the id_* control. ex_B = id_MB ? id_imm : resolved B; ex_Bst = resolved B.
- stall_count increments by 1 on each edge with stall && !hold && !rst, and saturates at all-ones.
- Latency: 1 cycle from ID to EX. A single load-use hazard costs exactly one bubble; on the next cycle the load is in WB and the operand comes from the WB forwarding path.
- A bubble never causes a register or flag write downstream.

Test Plan:
1. Reset: assert rst for 2 cycles with id_valid=1 -> all ex_* = 0 and stall_count = 0. On the first edge after release, ex_valid follows ID.
2. EX forward: previous instruction wrote R5=0x1234 (EX stage), ID reads AA=5 while A_data=0x0 -> ex_A = 0x1234 and stall = 0.
3. Both stages match: EX writes R7=0xAA and WB writes R7=0xBB, ID reads BA=7 -> ex_B = 0xAA, i.e. EX wins.
4. Load-use: EX is a load to R3 and ID uses AA=3 -> stall = 1 for one cycle and a bubble appears in EX. On the next cycle ex_A = wb_data and stall_count = 1.
5. Flag forward: EX has FS=3 with flags Z=1,C=1 and no RW; ID reads AA=31 -> ex_A = 0x9. If EX also has RW with DA=31 and result 0x55, then ex_A = 0x55.
6. Flush vs stall vs hold:
   - flush coincident with a load-use hazard -> stall = 0 and a bubble is loaded.
   - hold = 1 for 3 cycles -> ex_* outputs and stall_count are frozen.
   - R0 reads with EX DA=0 RW=1 -> raw A_data is used.
